// File: rtl/jtframe_fir_ctl.sv
// jtframe_fir_ctl: sequencing controller that sits between the sound mixer
// and the stereo FIR engine. It takes one stereo sample at a time over a
// valid/ready handshake, strobes it into the FIR, waits out the FIR's fixed
// computation window and then captures the filtered pair. Host coefficient
// writes are parked in a single pending slot and only applied while the
// controller is idle, so a coefficient never changes under a running filter.
module jtframe_fir_ctl #(
  parameter int TAPS = 69,
  parameter int CALC = 140,
  parameter int AW   = 7
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [15:0]   l_in,
  input  logic [15:0]   r_in,
  output logic          fir_sample,
  output logic [15:0]   fir_l,
  output logic [15:0]   fir_r,
  input  logic [15:0]   fir_l_out,
  input  logic [15:0]   fir_r_out,
  output logic [15:0]   l_out,
  output logic [15:0]   r_out,
  output logic          out_valid,
  input  logic          cfg_we,
  output logic          cfg_ready,
  input  logic [AW-1:0] cfg_addr,
  input  logic [15:0]   cfg_data,
  output logic          coef_we,
  output logic [AW-1:0] coef_addr,
  output logic [15:0]   coef_data,
  output logic          cfg_err
);

  localparam int            CW        = $clog2(CALC);
  localparam logic [CW-1:0] CALC_LOAD = CW'(CALC - 1);
  localparam logic [AW:0]   TAPS_LIM  = (AW + 1)'(TAPS);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_CFG,
    ST_FIRE,
    ST_CALC,
    ST_DONE
  } state_t;

  state_t        state_q,    state_d;
  logic [CW-1:0] cnt_q,      cnt_d;
  logic [15:0]   firL_q,     firL_d;
  logic [15:0]   firR_q,     firR_d;
  logic [15:0]   lOut_q,     lOut_d;
  logic [15:0]   rOut_q,     rOut_d;
  logic          outValid_q, outValid_d;
  logic          cfgPend_q,  cfgPend_d;
  logic [AW-1:0] cfgAddr_q,  cfgAddr_d;
  logic [15:0]   cfgData_q,  cfgData_d;
  logic          cfgErr_q,   cfgErr_d;

  logic addrOk;
  logic cfgAccept;
  logic sampleTake;

  // The address is widened by one bit so TAPS itself is representable even
  // when it equals 2**AW.
  assign addrOk     = ({1'b0, cfg_addr} < TAPS_LIM);
  assign cfgAccept  = cfg_we && !cfgPend_q;
  assign sampleTake = in_valid && in_ready;

  assign in_ready   = (state_q == ST_IDLE) && !cfgPend_q;
  assign cfg_ready  = !cfgPend_q;
  assign fir_sample = (state_q == ST_FIRE);
  assign coef_we    = (state_q == ST_CFG);
  assign coef_addr  = cfgAddr_q;
  assign coef_data  = cfgData_q;
  assign fir_l      = firL_q;
  assign fir_r      = firR_q;
  assign l_out      = lOut_q;
  assign r_out      = rOut_q;
  assign out_valid  = outValid_q;
  assign cfg_err    = cfgErr_q;

  // Next-state logic: the pending coefficient slot is filled in any state,
  // but it is drained only from IDLE, and it wins over a new sample there.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    firL_d     = firL_q;
    firR_d     = firR_q;
    lOut_d     = lOut_q;
    rOut_d     = rOut_q;
    outValid_d = 1'b0;
    cfgPend_d  = cfgPend_q;
    cfgAddr_d  = cfgAddr_q;
    cfgData_d  = cfgData_q;
    cfgErr_d   = 1'b0;

    if (cfgAccept) begin
      if (addrOk) begin
        cfgPend_d = 1'b1;
        cfgAddr_d = cfg_addr;
        cfgData_d = cfg_data;
      end else begin
        cfgErr_d = 1'b1;
      end
    end

    case (state_q)
      ST_IDLE: begin
        if (cfgPend_q) begin
          state_d = ST_CFG;
        end else if (sampleTake) begin
          firL_d  = l_in;
          firR_d  = r_in;
          state_d = ST_FIRE;
        end
      end
      ST_CFG: begin
        cfgPend_d = 1'b0;
        state_d   = ST_IDLE;
      end
      ST_FIRE: begin
        cnt_d   = CALC_LOAD;
        state_d = ST_CALC;
      end
      ST_CALC: begin
        // The counter reaches zero on the same edge that enters DONE, so
        // DONE lands exactly CALC cycles after the strobe.
        cnt_d = cnt_q - 1'b1;
        if (cnt_d == '0) begin
          state_d = ST_DONE;
        end
      end
      ST_DONE: begin
        lOut_d     = fir_l_out;
        rOut_d     = fir_r_out;
        outValid_d = 1'b1;
        state_d    = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // State and datapath registers; reset abandons any run and any pending write.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      cnt_q      <= '0;
      firL_q     <= '0;
      firR_q     <= '0;
      lOut_q     <= '0;
      rOut_q     <= '0;
      outValid_q <= 1'b0;
      cfgPend_q  <= 1'b0;
      cfgAddr_q  <= '0;
      cfgData_q  <= '0;
      cfgErr_q   <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      firL_q     <= firL_d;
      firR_q     <= firR_d;
      lOut_q     <= lOut_d;
      rOut_q     <= rOut_d;
      outValid_q <= outValid_d;
      cfgPend_q  <= cfgPend_d;
      cfgAddr_q  <= cfgAddr_d;
      cfgData_q  <= cfgData_d;
      cfgErr_q   <= cfgErr_d;
    end
  end

endmodule

// File: tb/tb_jtframe_fir_ctl.sv
// tb_jtframe_fir_ctl: bench for the FIR sequencing controller. The bench plays
// the FIR itself, driving a result that changes every cycle, so the captured
// value pins down exactly which cycle DONE sampled. Expected outputs are queued
// when a sample is sent and popped when out_valid pulses.
module tb_jtframe_fir_ctl;

  localparam int TAPS = 69;
  localparam int CALC = 140;
  localparam int AW   = 7;
  localparam int LAT  = CALC + 2;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic [15:0]   l_in = '0;
  logic [15:0]   r_in = '0;
  logic          fir_sample;
  logic [15:0]   fir_l;
  logic [15:0]   fir_r;
  logic [15:0]   fir_l_out;
  logic [15:0]   fir_r_out;
  logic [15:0]   l_out;
  logic [15:0]   r_out;
  logic          out_valid;
  logic          cfg_we = 1'b0;
  logic          cfg_ready;
  logic [AW-1:0] cfg_addr = '0;
  logic [15:0]   cfg_data = '0;
  logic          coef_we;
  logic [AW-1:0] coef_addr;
  logic [15:0]   coef_data;
  logic          cfg_err;

  typedef struct {
    int          cyc;
    logic [15:0] l;
    logic [15:0] r;
  } exp_t;

  exp_t sb[$];
  int   total = 0;
  int   bad   = 0;
  int   cyc   = 0;

  jtframe_fir_ctl #(.TAPS(TAPS), .CALC(CALC), .AW(AW)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready), .l_in(l_in), .r_in(r_in),
    .fir_sample(fir_sample), .fir_l(fir_l), .fir_r(fir_r),
    .fir_l_out(fir_l_out), .fir_r_out(fir_r_out),
    .l_out(l_out), .r_out(r_out), .out_valid(out_valid),
    .cfg_we(cfg_we), .cfg_ready(cfg_ready), .cfg_addr(cfg_addr), .cfg_data(cfg_data),
    .coef_we(coef_we), .coef_addr(coef_addr), .coef_data(coef_data), .cfg_err(cfg_err)
  );

  // Free-running 100 MHz clock.
  always #5 clk = ~clk;

  // Absolute cycle number, stable between rising edges.
  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [15:0] firModel(input int c, input bit right);
    logic [31:0] v;
    if (right) v = 32'(c * 37) + 32'h0000_8001;
    else       v = 32'(c * 13) ^ 32'h0000_5A5A;
    return v[15:0];
  endfunction

  assign fir_l_out = firModel(cyc, 1'b0);
  assign fir_r_out = firModel(cyc, 1'b1);

  // Scoreboard: every out_valid pulse must match the oldest queued expectation.
  always @(negedge clk) begin
    exp_t e;
    if (out_valid === 1'b1) begin
      total++;
      if (sb.size() == 0) begin
        bad++;
        $display("[TB] FAIL out_valid_unexpected: pulse seen at cycle %0d, none queued", cyc);
      end else begin
        e = sb.pop_front();
        if (cyc !== e.cyc) begin
          bad++;
          $display("[TB] FAIL out_valid_cycle: got cycle %0d want %0d", cyc, e.cyc);
        end
        total++;
        if (l_out !== e.l) begin
          bad++;
          $display("[TB] FAIL l_out_data: got %h want %h", l_out, e.l);
        end
        total++;
        if (r_out !== e.r) begin
          bad++;
          $display("[TB] FAIL r_out_data: got %h want %h", r_out, e.r);
        end
      end
    end
  end

  // Hard stop in case something hangs.
  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  task automatic nextCycle();
    @(negedge clk);
  endtask

  task automatic pushExpected(input int t);
    exp_t e;
    e.cyc = t + LAT;
    e.l   = firModel(t + LAT - 1, 1'b0);
    e.r   = firModel(t + LAT - 1, 1'b1);
    sb.push_back(e);
  endtask

  task automatic waitDrain();
    for (int i = 0; i < LAT + 10 && sb.size() != 0; i++) nextCycle();
    total++;
    if (sb.size() != 0) begin
      bad++;
      $display("[TB] FAIL scoreboard_drain: got %0d entries left want 0", sb.size());
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; in_valid = 1'b0; cfg_we = 1'b0;
    repeat (3) nextCycle();
    total++;
    if ({in_ready, cfg_ready} !== 2'b11) begin
      bad++; $display("[TB] FAIL reset_ready: got %b want 11", {in_ready, cfg_ready});
    end
    total++;
    if ({fir_sample, out_valid, coef_we, cfg_err} !== 4'b0000) begin
      bad++; $display("[TB] FAIL reset_pulses: got %b want 0000", {fir_sample, out_valid, coef_we, cfg_err});
    end
    total++;
    if ({fir_l, fir_r, l_out, r_out, coef_addr, coef_data} !== '0) begin
      bad++; $display("[TB] FAIL reset_data: got %h want 0", {fir_l, fir_r, l_out, r_out, coef_addr, coef_data});
    end
    rst = 1'b0;
    nextCycle();
    total++;
    if (in_ready !== 1'b1) begin
      bad++; $display("[TB] FAIL reset_release_ready: got %b want 1", in_ready);
    end
  endtask

  task automatic test_single();
    int t0;
    int lowBad;
    int pulseBad;
    logic [15:0] el;
    logic [15:0] er;
    nextCycle();
    total++;
    if (in_ready !== 1'b1) begin
      bad++; $display("[TB] FAIL single_ready0: got %b want 1", in_ready);
    end
    t0 = cyc;
    in_valid = 1'b1; l_in = 16'h1234; r_in = 16'hFEDC;
    pushExpected(t0);
    el = firModel(t0 + LAT - 1, 1'b0);
    er = firModel(t0 + LAT - 1, 1'b1);
    nextCycle();
    in_valid = 1'b0; l_in = '0; r_in = '0;
    total++;
    if ({fir_sample, fir_l, fir_r} !== {1'b1, 16'h1234, 16'hFEDC}) begin
      bad++; $display("[TB] FAIL single_strobe: got %b/%h/%h want 1/1234/fedc", fir_sample, fir_l, fir_r);
    end
    lowBad = 0; pulseBad = 0;
    for (int k = 1; k <= LAT - 1; k++) begin
      if (k > 1) nextCycle();
      if (in_ready !== 1'b0) lowBad++;
      if (k > 1 && fir_sample !== 1'b0) pulseBad++;
      if (out_valid !== 1'b0) pulseBad++;
    end
    total++;
    if (lowBad != 0) begin
      bad++; $display("[TB] FAIL single_busy_window: got %0d ready cycles want 0", lowBad);
    end
    total++;
    if (pulseBad != 0) begin
      bad++; $display("[TB] FAIL single_stray_pulse: got %0d stray cycles want 0", pulseBad);
    end
    nextCycle();
    total++;
    if ({out_valid, in_ready} !== 2'b11) begin
      bad++; $display("[TB] FAIL single_done: got %b want 11", {out_valid, in_ready});
    end
    nextCycle();
    total++;
    if ({out_valid, l_out, r_out} !== {1'b0, el, er}) begin
      bad++; $display("[TB] FAIL single_hold: got %b/%h/%h want 0/%h/%h", out_valid, l_out, r_out, el, er);
    end
    waitDrain();
  endtask

  task automatic test_back_to_back();
    logic [15:0] sl [3];
    logic [15:0] sr [3];
    logic fsExp;
    logic ovExp;
    int t0;
    int fsBad;
    int ovBad;
    int ovCount;
    sl[0] = 16'h0101; sl[1] = 16'h8000; sl[2] = 16'h7FFF;
    sr[0] = 16'hA5A5; sr[1] = 16'hFFFF; sr[2] = 16'h0001;
    fsBad = 0; ovBad = 0; ovCount = 0;
    nextCycle();
    t0 = cyc;
    for (int j = 0; j < 3; j++) pushExpected(t0 + j * LAT);
    for (int k = 0; k <= 3 * LAT + 10; k++) begin
      if (k > 0) nextCycle();
      fsExp = (k == 1 || k == LAT + 1 || k == 2 * LAT + 1);
      ovExp = (k == LAT || k == 2 * LAT || k == 3 * LAT);
      if (fir_sample !== fsExp) fsBad++;
      if (out_valid !== ovExp) ovBad++;
      if (out_valid === 1'b1) ovCount++;
      for (int j = 0; j < 3; j++) begin
        if (k == j * LAT + 1) begin
          total++;
          if ({fir_l, fir_r} !== {sl[j], sr[j]}) begin
            bad++; $display("[TB] FAIL b2b_sample%0d: got %h/%h want %h/%h", j, fir_l, fir_r, sl[j], sr[j]);
          end
        end
      end
      if (k == 0)           begin in_valid = 1'b1; l_in = sl[0]; r_in = sr[0]; end
      if (k == 1)           begin l_in = sl[1]; r_in = sr[1]; end
      if (k == LAT + 1)     begin l_in = sl[2]; r_in = sr[2]; end
      if (k == 2 * LAT + 1) begin in_valid = 1'b0; l_in = '0; r_in = '0; end
    end
    total++;
    if (fsBad != 0) begin
      bad++; $display("[TB] FAIL b2b_strobe_timing: got %0d bad cycles want 0", fsBad);
    end
    total++;
    if (ovBad != 0) begin
      bad++; $display("[TB] FAIL b2b_valid_timing: got %0d bad cycles want 0", ovBad);
    end
    total++;
    if (ovCount != 3) begin
      bad++; $display("[TB] FAIL b2b_valid_count: got %0d want 3", ovCount);
    end
    waitDrain();
  endtask

  task automatic test_cfg_during_run();
    int t0;
    int weBad;
    int rdyBad;
    logic weExp;
    weBad = 0; rdyBad = 0;
    nextCycle();
    t0 = cyc;
    in_valid = 1'b1; l_in = 16'h4321; r_in = 16'h0F0F;
    pushExpected(t0);
    for (int k = 1; k <= LAT + 6; k++) begin
      nextCycle();
      weExp = (k == LAT + 1);
      if (coef_we !== weExp) weBad++;
      if (k >= 13 && k <= LAT + 1 && cfg_ready !== 1'b0) rdyBad++;
      if (k == 12) begin
        total++;
        if (cfg_ready !== 1'b1) begin
          bad++; $display("[TB] FAIL run_cfg_ready_before: got %b want 1", cfg_ready);
        end
      end
      if (k == LAT) begin
        total++;
        if (in_ready !== 1'b0) begin
          bad++; $display("[TB] FAIL run_pending_blocks_sample: got %b want 0", in_ready);
        end
      end
      if (k == LAT + 1) begin
        total++;
        if ({coef_addr, coef_data} !== {7'd34, 16'd7000}) begin
          bad++; $display("[TB] FAIL run_coef_write: got %0d/%0d want 34/7000", coef_addr, coef_data);
        end
      end
      if (k == LAT + 2) begin
        total++;
        if ({cfg_ready, in_ready} !== 2'b11) begin
          bad++; $display("[TB] FAIL run_cfg_release: got %b want 11", {cfg_ready, in_ready});
        end
      end
      if (k == 1)  begin in_valid = 1'b0; l_in = '0; r_in = '0; end
      if (k == 12) begin cfg_we = 1'b1; cfg_addr = 7'd34; cfg_data = 16'd7000; end
      if (k == 13) begin cfg_we = 1'b0; end
    end
    total++;
    if (weBad != 0) begin
      bad++; $display("[TB] FAIL run_coef_we_timing: got %0d bad cycles want 0", weBad);
    end
    total++;
    if (rdyBad != 0) begin
      bad++; $display("[TB] FAIL run_cfg_ready_low: got %0d bad cycles want 0", rdyBad);
    end
    waitDrain();
  endtask

  task automatic test_simultaneous();
    int t;
    nextCycle();
    cfg_we = 1'b1; cfg_addr = 7'd0; cfg_data = 16'hFFF1;
    nextCycle();
    cfg_we = 1'b0;
    total++;
    if ({in_ready, cfg_ready} !== 2'b00) begin
      bad++; $display("[TB] FAIL simul_pending: got %b want 00", {in_ready, cfg_ready});
    end
    in_valid = 1'b1; l_in = 16'h00AA; r_in = 16'hFF55;
    nextCycle();
    total++;
    if ({coef_we, coef_addr, coef_data, in_ready, fir_sample} !== {1'b1, 7'd0, 16'hFFF1, 1'b0, 1'b0}) begin
      bad++; $display("[TB] FAIL simul_cfg_first: got %b/%0d/%h/%b/%b want 1/0/fff1/0/0",
                      coef_we, coef_addr, coef_data, in_ready, fir_sample);
    end
    nextCycle();
    total++;
    if ({in_ready, coef_we} !== 2'b10) begin
      bad++; $display("[TB] FAIL simul_ready_return: got %b want 10", {in_ready, coef_we});
    end
    t = cyc;
    pushExpected(t);
    nextCycle();
    in_valid = 1'b0; l_in = '0; r_in = '0;
    total++;
    if ({fir_sample, fir_l, fir_r} !== {1'b1, 16'h00AA, 16'hFF55}) begin
      bad++; $display("[TB] FAIL simul_strobe: got %b/%h/%h want 1/00aa/ff55", fir_sample, fir_l, fir_r);
    end
    waitDrain();
  endtask

  task automatic test_bad_addr();
    int errBad;
    errBad = 0;
    nextCycle();
    cfg_we = 1'b1; cfg_addr = 7'd69; cfg_data = 16'h3333;
    nextCycle();
    cfg_we = 1'b0;
    total++;
    if ({cfg_err, cfg_ready, coef_we} !== 3'b110) begin
      bad++; $display("[TB] FAIL bad69_err: got %b want 110", {cfg_err, cfg_ready, coef_we});
    end
    for (int i = 0; i < 6; i++) begin
      nextCycle();
      if ({cfg_err, cfg_ready, coef_we} !== 3'b010) errBad++;
    end
    total++;
    if (errBad != 0) begin
      bad++; $display("[TB] FAIL bad69_quiet: got %0d bad cycles want 0", errBad);
    end
    cfg_we = 1'b1; cfg_addr = 7'd127; cfg_data = 16'h4444;
    nextCycle();
    cfg_we = 1'b0;
    total++;
    if ({cfg_err, cfg_ready} !== 2'b11) begin
      bad++; $display("[TB] FAIL bad127_err: got %b want 11", {cfg_err, cfg_ready});
    end
    nextCycle();
    cfg_we = 1'b1; cfg_addr = 7'd68; cfg_data = 16'h8001;
    nextCycle();
    cfg_we = 1'b0;
    total++;
    if ({cfg_err, cfg_ready} !== 2'b00) begin
      bad++; $display("[TB] FAIL top_addr_accept: got %b want 00", {cfg_err, cfg_ready});
    end
    nextCycle();
    total++;
    if ({coef_we, coef_addr, coef_data} !== {1'b1, 7'd68, 16'h8001}) begin
      bad++; $display("[TB] FAIL top_addr_write: got %b/%0d/%h want 1/68/8001", coef_we, coef_addr, coef_data);
    end
    nextCycle();
    total++;
    if ({cfg_ready, coef_we} !== 2'b10) begin
      bad++; $display("[TB] FAIL top_addr_release: got %b want 10", {cfg_ready, coef_we});
    end
  endtask

  task automatic test_reset_mid_calc();
    int abortBad;
    abortBad = 0;
    nextCycle();
    in_valid = 1'b1; l_in = 16'h7777; r_in = 16'h8888;
    for (int k = 1; k <= 30; k++) begin
      nextCycle();
      if (k == 21) begin
        total++;
        if (cfg_ready !== 1'b0) begin
          bad++; $display("[TB] FAIL abort_pending_set: got %b want 0", cfg_ready);
        end
      end
      if (k == 1)  begin in_valid = 1'b0; l_in = '0; r_in = '0; end
      if (k == 20) begin cfg_we = 1'b1; cfg_addr = 7'd5; cfg_data = 16'h1111; end
      if (k == 21) cfg_we = 1'b0;
      if (k == 30) rst = 1'b1;
    end
    nextCycle();
    rst = 1'b0;
    total++;
    if ({in_ready, cfg_ready} !== 2'b11) begin
      bad++; $display("[TB] FAIL abort_idle: got %b want 11", {in_ready, cfg_ready});
    end
    total++;
    if ({fir_sample, out_valid, coef_we, cfg_err} !== 4'b0000) begin
      bad++; $display("[TB] FAIL abort_pulses: got %b want 0000", {fir_sample, out_valid, coef_we, cfg_err});
    end
    total++;
    if ({fir_l, fir_r, l_out, r_out, coef_addr, coef_data} !== '0) begin
      bad++; $display("[TB] FAIL abort_data: got %h want 0", {fir_l, fir_r, l_out, r_out, coef_addr, coef_data});
    end
    for (int i = 0; i < LAT + 20; i++) begin
      nextCycle();
      if ({out_valid, coef_we, fir_sample} !== 3'b000) abortBad++;
    end
    total++;
    if (abortBad != 0) begin
      bad++; $display("[TB] FAIL abort_no_activity: got %0d bad cycles want 0", abortBad);
    end
  endtask

  // Test sequence.
  initial begin
    test_reset();
    test_single();
    test_back_to_back();
    test_cfg_during_run();
    test_simultaneous();
    test_bad_addr();
    test_reset_mid_calc();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
